fe_mul_pm: RTL and testbench



---
 rtl/fe_pkg.sv | 35 +++
 rtl/fe_fold.sv | 25 ++
 rtl/fe_mul_pm.sv | 123 ++++++++++++
 tb/tb_fe_mul_pm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fe_pkg : shared constants, state encoding and prime helper for the    |
// |          pseudo-Mersenne field multiplier.                            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package fe_pkg;

    localparam int FE_W_DEF = 255;
    localparam int FE_C_DEF = 19;
    localparam int FE_D_DEF = 17;
    localparam int FE_MAXW  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_FOLD  = 3'd2,
        ST_CANON = 3'd3,
        ST_DONE  = 3'd4
    } fe_state_t;

    // p = 2^w - c, returned in a wide container; callers slice what they need.
    function automatic logic [FE_MAXW-1:0] fe_prime(input int w, input int c);
        logic [FE_MAXW-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v - FE_MAXW'(c);
    endfunction

    function automatic int fe_ndig(input int w, input int d);
        return (w + d - 1) / d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fe_fold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fe_fold : combinational fold t[W-1:0] + C*(t >> W) for an IW-bit t.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fe_fold #(
    parameter int W  = 255,
    parameter int C  = 19,
    parameter int IW = 274
) (
    input  logic [IW-1:0] i_t,
    output logic [W:0]    o_t
);

    localparam int          HW    = IW - W;
    localparam logic [15:0] C_OFF = 16'(C);

    logic [HW+15:0] w_prod;

    // Callers keep the high part small enough that the sum fits in W+1 bits.
    assign w_prod = {16'b0, i_t[IW-1:W]} * {{HW{1'b0}}, C_OFF};
    assign o_t    = {1'b0, i_t[W-1:0]} + (W+1)'(w_prod);

endmodule
`default_nettype wire

// File: rtl/fe_mul_pm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fe_mul_pm : digit-serial (a*b) mod (2^W - C) with squaring mode and   |
// |             start/ready/done handshake; canonical result.             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fe_mul_pm
    import fe_pkg::*;
#(
    parameter int W = FE_W_DEF,
    parameter int C = FE_C_DEF,
    parameter int D = FE_D_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         sq,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] out
);

    localparam int NDIG = fe_ndig(W, D);
    localparam int RBW  = NDIG * D;
    localparam int IW   = W + D + 2;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [FE_MAXW-1:0] P_FULL = fe_prime(W, C);
    localparam logic [W:0]         P      = P_FULL[W:0];

    fe_state_t        r_state;
    logic [KW-1:0]    r_k;
    logic [W-1:0]     r_ra;
    logic [RBW-1:0]   r_rb;
    logic [W:0]       r_acc;
    logic [W-1:0]     r_out;
    logic             r_ready;
    logic             r_done;

    logic [D-1:0]     w_digit;
    logic [W+D-1:0]   w_pp;
    logic [IW-1:0]    w_mac;
    logic [W:0]       w_mul_fold;
    logic [W:0]       w_fin_fold;
    logic [W-1:0]     w_canon;

    // acc < 2^(W+1) and digit product < 2^(W+D) keep the Horner step below 2^(W+D+2).
    assign w_digit = r_rb[r_k*D +: D];
    assign w_pp    = {{D{1'b0}}, r_ra} * {{W{1'b0}}, w_digit};
    assign w_mac   = {1'b0, r_acc, {D{1'b0}}} + {2'b00, w_pp};
    assign w_canon = (r_acc >= P) ? W'(r_acc - P) : r_acc[W-1:0];

    fe_fold #(.W(W), .C(C), .IW(IW)) u_fold_mul (
        .i_t (w_mac),
        .o_t (w_mul_fold)
    );

    fe_fold #(.W(W), .C(C), .IW(W + 1)) u_fold_fin (
        .i_t (r_acc),
        .o_t (w_fin_fold)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= RBW'(sq ? a : b);
                        r_acc   <= '0;
                        r_k     <= KW'(NDIG - 1);
                        r_state <= ST_MUL;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_MUL: begin
                    r_acc <= w_mul_fold;
                    if (r_k == '0) begin
                        r_state <= ST_FOLD;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                ST_FOLD: begin
                    // Residue below 2^W after this step, so one subtraction canonicalises.
                    r_acc   <= w_fin_fold;
                    r_state <= ST_CANON;
                end
                ST_CANON: begin
                    r_out   <= w_canon;
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign out   = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fe_mul_pm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fe_mul_pm : directed + scoreboard bench for fe_mul_pm (default     |
// |                255-bit field and a W=8 instance).                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_fe_mul_pm;

    localparam int              W0 = 255;
    localparam logic [W0-1:0]   P0 = {W0{1'b1}} - W0'(18);
    localparam int              LAT0 = 17;
    localparam int              LAT1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s0_start, s0_sq, d0_ready, d0_done;
    logic [W0-1:0] s0_a, s0_b, d0_out;
    logic          s1_start, s1_sq, d1_ready, d1_done;
    logic [7:0]    s1_a, s1_b, d1_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [W0-1:0] q0[$];
    logic [7:0]    q1[$];

    fe_mul_pm u_dut0 (
        .clock(clk), .reset_n(rst_n), .start(s0_start), .sq(s0_sq),
        .a(s0_a), .b(s0_b), .ready(d0_ready), .done(d0_done), .out(d0_out)
    );

    fe_mul_pm #(.W(8), .C(5), .D(3)) u_dut1 (
        .clock(clk), .reset_n(rst_n), .start(s1_start), .sq(s1_sq),
        .a(s1_a), .b(s1_b), .ready(d1_ready), .done(d1_done), .out(d1_out)
    );

    function automatic logic [W0-1:0] model0(input logic [W0-1:0] x, input logic [W0-1:0] y);
        logic [2*W0-1:0] pr;
        pr = {{W0{1'b0}}, x} * {{W0{1'b0}}, y};
        pr = pr % {{W0{1'b0}}, P0};
        return pr[W0-1:0];
    endfunction

    function automatic logic [7:0] model1(input int x, input int y);
        return 8'((x * y) % 251);
    endfunction

    function automatic logic [W0-1:0] rnd0();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[W0-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W0-1:0] got, input logic [W0-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue0(input logic [W0-1:0] x, input logic [W0-1:0] y, input logic m, input bit hold);
        int n = 0;
        while (d0_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready0_wait", W0'(d0_ready), W0'(1'b1));
        s0_start = 1'b1; s0_a = x; s0_b = y; s0_sq = m;
        @(posedge clk);
        q0.push_back(model0(x, m ? x : y));
        #1;
        s0_start = hold; s0_a = rnd0(); s0_b = rnd0(); s0_sq = ~m;
    endtask

    task automatic wait_done0(input int cyc0, output logic [W0-1:0] got);
        int            cyc = cyc0;
        bit            seen = 0;
        bit            early_rdy = 0;
        logic [W0-1:0] exp;
        while (!seen && cyc < 100) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (d0_done === 1'b1) seen = 1;
            else if (d0_ready !== 1'b0) early_rdy = 1;
        end
        got = d0_out;
        chk("done0_latency", W0'(cyc), W0'(LAT0));
        chk("ready0_busy", W0'(early_rdy), W0'(0));
        exp = (q0.size() > 0) ? q0.pop_front() : {W0{1'bx}};
        chk("out0", got, exp);
    endtask

    task automatic issue1(input int x, input int y, input logic m);
        int n = 0;
        while (d1_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready1_wait", W0'(d1_ready), W0'(1'b1));
        s1_start = 1'b1; s1_a = 8'(x); s1_b = 8'(y); s1_sq = m;
        @(posedge clk);
        q1.push_back(model1(x, m ? x : y));
        #1;
        s1_start = 1'b0; s1_a = 8'($urandom); s1_b = 8'($urandom); s1_sq = ~m;
    endtask

    task automatic wait_done1(output logic [7:0] got);
        int         cyc = 0;
        bit         seen = 0;
        logic [7:0] exp;
        while (!seen && cyc < 50) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (d1_done === 1'b1) seen = 1;
        end
        got = d1_out;
        chk("done1_latency", W0'(cyc), W0'(LAT1));
        exp = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        chk("out1", W0'(got), W0'(exp));
    endtask

    initial begin
        logic [W0-1:0] v, g0;
        logic [7:0]    g1;
        bit            stray;
        int            rows[6] = '{0, 1, 250, 251, 252, 255};

        rst_n = 1'b0;
        s0_start = 1'b0; s0_sq = 1'b0; s0_a = '0; s0_b = '0;
        s1_start = 1'b1; s1_sq = 1'b0; s1_a = 8'd7; s1_b = 8'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", W0'(d0_ready), W0'(1'b1));
        chk("rst_done0",  W0'(d0_done),  W0'(1'b0));
        chk("rst_out0",   d0_out,        '0);
        chk("rst_ready1", W0'(d1_ready), W0'(1'b1));
        chk("rst_done1",  W0'(d1_done),  W0'(1'b0));
        chk("rst_out1",   W0'(d1_out),   '0);
        @(posedge clk);
        #1; rst_n = 1'b1; s1_start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", W0'(d1_ready), W0'(1'b1));

        // 2^128 squared
        v = '0; v[128] = 1'b1;
        issue0(v, rnd0(), 1'b1, 0);
        wait_done0(0, g0);
        chk("sq_2p128", g0, W0'(38));
        repeat (3) @(negedge clk);
        chk("out0_hold", d0_out, W0'(38));
        chk("done0_pulse", W0'(d0_done), W0'(1'b0));

        issue0({W0{1'b1}}, W0'(1), 1'b0, 0);
        wait_done0(0, g0);
        chk("allones_x1", g0, W0'(18));

        v = '0; v[127:0] = '1;
        issue0(v, W0'(1) | (W0'(1) << 128), 1'b0, 0);
        wait_done0(0, g0);
        chk("diff_squares", g0, W0'(37));

        issue0('0, rnd0(), 1'b0, 0);
        wait_done0(0, g0);
        chk("zero_a", g0, '0);

        // Known vector, start held high through busy cycles and the DONE cycle
        issue0(255'h6483b328032df78f6abb1342dc54964127be97507e17c1b4cf481339f1fa20de,
               255'hb47d26181c9f63bb1405345faca4ffd0fe748b6652fa7d2decf0e2c865e988d, 1'b0, 1);
        wait_done0(0, g0);
        chk("known_vec", g0, 255'h7587e6935be3c0628e7fa76da3931343283adb49a03f048998eb0f9b51a209ef);
        issue0(rnd0(), rnd0(), 1'b0, 0);
        wait_done0(0, g0);

        issue0(P0, rnd0(), 1'b0, 0);
        wait_done0(0, g0);
        chk("a_eq_p", g0, '0);
        issue0({W0{1'b1}}, rnd0(), 1'b1, 0);
        wait_done0(0, g0);
        for (int i = 0; i < 6; i++) begin
            issue0(rnd0(), rnd0(), 1'($urandom), 0);
            wait_done0(0, g0);
        end

        // Start pulse with new operands while busy is ignored
        issue0(rnd0(), rnd0(), 1'b0, 0);
        repeat (2) @(posedge clk);
        #1; s0_start = 1'b1; s0_a = rnd0(); s0_b = rnd0();
        @(posedge clk);
        #1; s0_start = 1'b0;
        wait_done0(3, g0);

        // Reset during MUL step 5 aborts without done
        issue0(rnd0(), rnd0(), 1'b0, 0);
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk);
        #1; rst_n = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("abort_done0",  W0'(d0_done),  W0'(1'b0));
        chk("abort_out0",   d0_out,        '0);
        chk("abort_ready0", W0'(d0_ready), W0'(1'b1));
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (d0_done !== 1'b0) stray = 1;
        end
        chk("abort_no_done", W0'(stray), W0'(0));
        issue0(rnd0(), rnd0(), 1'b0, 0);
        wait_done0(0, g0);

        // W=8, C=5, D=3 instance
        issue1(200, 200, 1'b0);
        wait_done1(g1);
        chk("w8_200x200", W0'(g1), W0'(91));
        foreach (rows[r]) begin
            for (int y = 0; y < 256; y++) begin
                issue1(rows[r], y, 1'b0);
                wait_done1(g1);
            end
        end
        for (int i = 0; i < 800; i++) begin
            issue1(int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom));
            wait_done1(g1);
        end

        chk("q0_drained", W0'(q0.size()), '0);
        chk("q1_drained", W0'(q1.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
